mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised, multi-channel successor to the CPU's memory controller: arbitrates up to `NCH` word/half/byte requesters (ICache, LSB, future DCache/prefetcher) onto the single byte-serial RAM/IO bus. It supports fixed or round-robin priority and per-channel speculative-flush masking on `jp_wrong`. It stalls IO writes on `io_buffer_full` and freezes cleanly on `rdy` low. It sits between the requester blocks and the `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins of `cpu`.

## Interface
- `NCH`, 2: number of requester channels (1..8).
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `FLUSH_MASK`, 'b01: bit i set means channel i reads are aborted on `jp_wrong`.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: pause when low.
- `jp_wrong` in 1: misprediction flush pulse from ROB.
- `req` in NCH: per-channel request, held until `ack`.
- `we` in NCH: per-channel write enable.
- `size` in 2·NCH: per-channel byte count minus 1 (0 = 1 B, 1 = 2 B, 3 = 4 B; 2 is illegal and treated as 3).
- `addr` in 32·NCH: per-channel byte address.
- `wdata` in 32·NCH: per-channel store data, little-endian.
- `ack` out NCH: one-cycle completion pulse for the granted channel.
- `rdata` out 32: read data, zero-extended, valid during `ack`.
- `busy` out 1: high when state ≠ IDLE.
- `io_buffer_full` in 1: UART full.
- `mem_din` in 8: RAM read byte, valid the cycle after issue.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write.

## Operation
- States: IDLE, READ, WRITE, IO_WAIT, DONE.
- IDLE: samples `req`. Requests from FLUSH_MASK channels are ignored in a cycle where `jp_wrong` is high.
  - Fixed mode: grants the lowest set index.
  - Round-robin mode: searches from `last_grant+1` modulo NCH. `last_grant` updates on each grant and resets to NCH-1.
  - Latches `addr`, `size`, `we`, `wdata` of the winner and goes to READ or WRITE. Byte counter `k` = 0.
- READ: drives `mem_a = addr+k`, `mem_wr = 0` and increments `k` each active cycle.
  - `mem_din` is captured into `rdata[8(k-1)+:8]` only in a cycle following an active issue cycle.
  - After the last byte's data is captured, goes to DONE.
  - Bytes above `size` stay 0.
- WRITE: drives `mem_a = addr+k`, `mem_dout = wdata[8k+:8]`, `mem_wr = 1`. After the byte where `k == size` is issued, goes to DONE.
  - If `addr[17:16] == 2'b11` and `io_buffer_full` is high, enters IO_WAIT instead of issuing. IO_WAIT drives `mem_wr = 0` and returns to WRITE at the same `k` once `io_buffer_full` is low.
- DONE: pulses `ack[grant]` for one cycle, ignores `req`, then returns to IDLE. The requester drops `req` no later than the cycle after `ack`.
- Flush: `jp_wrong` high while in READ with a FLUSH_MASK grant goes to IDLE next edge with no `ack`. `rdata` keeps its partial value, which is don't-care.
  - WRITE and IO_WAIT are never aborted, and neither are non-masked reads.
- Pause: with `rdy` low, state, `k`, `rdata` and `last_grant` all hold, and `mem_wr` is forced to 0.
  - A read byte issued in the cycle before the pause is not captured; that address is re-issued on resume.
  - Writes hold `k` and repeat the byte on resume.
- Outside READ/WRITE: `mem_a = 0`, `mem_wr = 0`, `mem_dout = 0`.
- Reset: state = IDLE, `k = 0`, `ack = 0`, `rdata = 0`, `busy = 0`, `mem_a = 0`, `mem_dout = 0`, `mem_wr = 0`, `last_grant = NCH-1`.

## Timing
- All outputs are registered except `mem_a`/`mem_dout`/`mem_wr`, which decode from registered state, `k` and latched fields.
- Grant at edge ending cycle t, with `req` seen in IDLE.
- n-byte read: bytes issued at cycles t+1..t+n, last data captured at the end of t+n+1, `ack` at t+n+2. A 4 B read takes 6 cycles from request.
- n-byte write: bytes at t+1..t+n, `ack` at t+n+1, plus one cycle per IO_WAIT cycle.
- Earliest next grant is in the IDLE cycle immediately after DONE.
- Simultaneous `req` on all channels in round-robin mode gives grants in rotating order with no channel starved beyond NCH-1 transactions.
- `jp_wrong` in the same cycle as a masked channel's `req` in IDLE: no grant.
- `jp_wrong` in DONE: `ack` still fires; the requester discards it.

## Test plan
- NCH=2, fixed mode; ch1 4 B read of 0x100 with RAM bytes 11 22 33 44 → `mem_a` 0x100..0x103 in cycles 1-4, `ack[1]` at cycle 6, `rdata = 0x44332211`.
- Fixed mode, ch0 and ch1 request together → ch0 served first. Round-robin mode, both held for 4 transactions → grants 0,1,0,1.
- ch0 (masked) 4 B read, `jp_wrong` after byte 2 → IDLE next cycle, no `ack`. A ch1 (unmasked) read under the same stimulus completes with correct data.
- 1 B write 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` stays 0 for 3 cycles, then a single write of 0x41, then `ack`.
- `rdy` low for 2 cycles during a 2 B read after byte 0 is issued → byte 0 address re-issued, `rdata` correct, `ack` delayed by exactly 3 cycles. No write pulses occur during pause.
- Assert `rst` asynchronously mid-WRITE → all outputs 0 immediately and state IDLE. Next request behaves as after power-up.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester-side bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int NCH = 2
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [2*NCH-1:0]  size;
  logic [32*NCH-1:0] addr;
  logic [32*NCH-1:0] wdata;
  logic [NCH-1:0]    ack;
  logic [31:0]       rdata;
  logic              busy;

  modport master (output req, we, size, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, size, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - NCH-channel arbiter onto the byte-serial RAM/IO bus
module mem_arbiter #(
  parameter int         NCH        = 2,
  parameter int         ARB_MODE   = 0,
  parameter logic [7:0] FLUSH_MASK = 8'b01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         jp_wrong,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus,
  input  logic [7:0]   mem_din,
  output logic [7:0]   mem_dout,
  output logic [31:0]  mem_a,
  output logic         mem_wr
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, READ, WRITE, IO_WAIT, DONE} state_t;

  state_t         state;
  logic [GW-1:0]  grant;
  logic [GW-1:0]  last_grant;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [1:0]     size_q;
  logic [2:0]     k;
  logic           issued;
  logic [NCH-1:0] ack_q;
  logic [31:0]    rdata_q;
  logic           busy_q;

  logic [NCH-1:0] elig;
  logic           found;
  logic [GW-1:0]  win;
  logic [GW-1:0]  cand;
  logic [1:0]     win_size;
  logic [2:0]     km1;
  logic           io_stall;

  assign elig     = bus.req & ~(jp_wrong ? FLUSH_MASK[NCH-1:0] : {NCH{1'b0}});
  assign win_size = bus.size[2*int'(win) +: 2];
  assign km1      = k - 3'd1;
  assign io_stall = (addr_q[17:16] == 2'b11) && io_buffer_full;

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  // Round-robin scans upward from the channel after the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found) begin
        if (ARB_MODE == 0) cand = GW'(i);
        else               cand = GW'((int'(last_grant) + 1 + i) % NCH);
        if (elig[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state == READ || state == WRITE) mem_a = addr_q + {29'd0, k};
    if (state == WRITE) begin
      mem_dout = wdata_q[{k[1:0], 3'b000} +: 8];
      mem_wr   = rdy && !io_stall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NCH - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      k          <= '0;
      issued     <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      if (rdy) begin
        case (state)
          IDLE: begin
            if (found) begin
              grant      <= win;
              last_grant <= win;
              addr_q     <= bus.addr[32*int'(win) +: 32];
              wdata_q    <= bus.wdata[32*int'(win) +: 32];
              size_q     <= (win_size == 2'd2) ? 2'd3 : win_size;
              k          <= '0;
              issued     <= 1'b0;
              rdata_q    <= '0;
              busy_q     <= 1'b1;
              state      <= bus.we[win] ? WRITE : READ;
            end
          end
          READ: begin
            if (jp_wrong && FLUSH_MASK[grant]) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              issued <= 1'b0;
            end else begin
              if (issued) rdata_q[{km1[1:0], 3'b000} +: 8] <= mem_din;
              if (k <= {1'b0, size_q}) begin
                k      <= k + 3'd1;
                issued <= 1'b1;
              end else begin
                issued       <= 1'b0;
                ack_q[grant] <= 1'b1;
                state        <= DONE;
              end
            end
          end
          WRITE: begin
            if (io_stall) begin
              state <= IO_WAIT;
            end else if (k[1:0] == size_q) begin
              ack_q[grant] <= 1'b1;
              state        <= DONE;
            end else begin
              k <= k + 3'd1;
            end
          end
          IO_WAIT: begin
            if (!io_buffer_full) state <= WRITE;
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end else if (state == READ && issued) begin
        // The byte issued just before the pause is lost; rewind so it is re-issued.
        k      <= km1;
        issued <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic jp_wrong = 1'b0;
  logic io_full = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NCH(2)) bf();
  mem_arbiter_if #(.NCH(2)) br();

  logic [7:0]  f_din, f_dout, r_din, r_dout;
  logic [31:0] f_a, r_a;
  logic        f_wr, r_wr;

  mem_arbiter #(.NCH(2), .ARB_MODE(0), .FLUSH_MASK(8'b01)) dut_fix (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .io_buffer_full(io_full),
    .bus(bf), .mem_din(f_din), .mem_dout(f_dout), .mem_a(f_a), .mem_wr(f_wr));

  mem_arbiter #(.NCH(2), .ARB_MODE(1), .FLUSH_MASK(8'b01)) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .io_buffer_full(io_full),
    .bus(br), .mem_din(r_din), .mem_dout(r_dout), .mem_a(r_a), .mem_wr(r_wr));

  // RAM image: 0x100..0x103 holds 11 22 33 44.
  function automatic logic [7:0] ram(input logic [31:0] a);
    logic [7:0] b;
    b = ({6'd0, a[1:0]} + 8'd1) * 8'd17;
    return b ^ {2'b00, a[7:2]};
  endfunction

  always @(posedge clk) begin
    f_din <= ram(f_a);
    r_din <= ram(r_a);
  end

  typedef struct {
    int          ch;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          jp_cyc;
    int          rdy_s;
    int          rdy_n;
    int          full_n;
    int          exp_ack;
    logic [31:0] exp_rd;
    int          exp_a1;
  } vec_t;

  vec_t        vt[15];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] alog[0:31];
  logic        blog[0:31];
  logic [31:0] wlog_a[0:7];
  logic [7:0]  wlog_d[0:7];
  int          nwr, wr1, ack_cyc, nack;
  logic [1:0]  ackbits;
  logic [31:0] rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    bf.req                   = '0;
    bf.we[v.ch]              = v.we;
    bf.size[2*v.ch +: 2]     = v.sz;
    bf.addr[32*v.ch +: 32]   = v.addr;
    bf.wdata[32*v.ch +: 32]  = v.wdata;
    bf.req[v.ch]             = 1'b1;
    jp_wrong = (v.jp_cyc == 0);
    io_full  = (v.full_n > 0);
    rdy      = 1'b1;
    ack_cyc = 0; nack = 0; nwr = 0; wr1 = 0; rd = '0; ackbits = '0;
    for (int c = 1; c < 24; c++) begin
      @(posedge clk);
      @(negedge clk);
      jp_wrong = (c == v.jp_cyc);
      io_full  = (c < v.full_n);
      rdy      = !(c >= v.rdy_s && c < v.rdy_s + v.rdy_n);
      if (c == v.jp_cyc) bf.req = '0;
      #1;
      alog[c] = f_a;
      blog[c] = bf.busy;
      if (f_wr) begin
        if (nwr < 8) begin
          wlog_a[nwr] = f_a;
          wlog_d[nwr] = f_dout;
        end
        if (nwr == 0) wr1 = c;
        nwr++;
      end
      if (bf.ack != 2'b00) begin
        nack++;
        if (ack_cyc == 0) begin
          ack_cyc = c;
          rd      = bf.rdata;
          ackbits = bf.ack;
        end
        bf.req = '0;
      end
    end
    jp_wrong = 1'b0;
    io_full  = 1'b0;
    rdy      = 1'b1;
    bf.req   = '0;
  endtask

  initial begin
    int          n;
    int          got;
    logic [1:0]  ord[0:3];
    logic [31:0] rds[0:3];
    logic [31:0] wd;

    //       ch we sz   addr         wdata         jp  rs rn fn ack rdata          a1
    vt[0]  = '{1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         -1, 0, 0, 0, 6, 32'h4433_2211, 1};
    vt[1]  = '{0, 1'b0, 2'd0, 32'h0000_0107, 32'h0,         -1, 0, 0, 0, 3, 32'h0000_0045, 1};
    vt[2]  = '{0, 1'b0, 2'd2, 32'h0000_0010, 32'h0,         -1, 0, 0, 0, 6, 32'h4037_2615, 1};
    vt[3]  = '{1, 1'b0, 2'd1, 32'h0000_0100, 32'h0,         -1, 0, 0, 0, 4, 32'h0000_2211, 1};
    vt[4]  = '{1, 1'b1, 2'd3, 32'h0000_2000, 32'hDEAD_BEEF, -1, 0, 0, 0, 5, 32'h0,         1};
    vt[5]  = '{0, 1'b1, 2'd1, 32'h0003_0004, 32'h0000_1234, -1, 0, 0, 0, 3, 32'h0,         1};
    vt[6]  = '{0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, -1, 0, 0, 3, 5, 32'h0,         4};
    vt[7]  = '{0, 1'b0, 2'd3, 32'h0000_0100, 32'h0,          3, 0, 0, 0, 0, 32'h0,         1};
    vt[8]  = '{1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,          3, 0, 0, 0, 6, 32'h4433_2211, 1};
    vt[9]  = '{0, 1'b0, 2'd0, 32'h0000_0107, 32'h0,          3, 0, 0, 0, 3, 32'h0000_0045, 1};
    vt[10] = '{0, 1'b0, 2'd0, 32'h0000_0107, 32'h0,          0, 0, 0, 0, 4, 32'h0000_0045, 2};
    vt[11] = '{1, 1'b0, 2'd0, 32'h0000_0107, 32'h0,          0, 0, 0, 0, 3, 32'h0000_0045, 1};
    vt[12] = '{1, 1'b0, 2'd1, 32'h0000_0204, 32'h0,         -1, 2, 2, 0, 7, 32'h0000_2310, 1};
    vt[13] = '{1, 1'b1, 2'd0, 32'h0000_0040, 32'h0000_005A, -1, 1, 1, 0, 3, 32'h0,         2};
    vt[14] = '{0, 1'b1, 2'd0, 32'h0001_0040, 32'h0000_0077, -1, 0, 0, 3, 2, 32'h0,         1};

    bf.req = '0; bf.we = '0; bf.size = '0; bf.addr = '0; bf.wdata = '0;
    br.req = '0; br.we = '0; br.size = '0; br.addr = '0; br.wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy",     32'(bf.busy),  32'h0);
    chk("rst ack",      32'(bf.ack),   32'h0);
    chk("rst rdata",    bf.rdata,      32'h0);
    chk("rst mem_a",    f_a,           32'h0);
    chk("rst mem_dout", 32'(f_dout),   32'h0);
    chk("rst mem_wr",   32'(f_wr),     32'h0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a 4-byte write.
    @(negedge clk);
    bf.we[0] = 1'b1; bf.size[1:0] = 2'd3; bf.addr[31:0] = 32'h2000; bf.wdata[31:0] = 32'hCAFE_F00D;
    bf.req[0] = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("arst pre mem_wr", 32'(f_wr), 32'h1);
    chk("arst pre mem_a",  f_a,       32'h2001);
    #2 rst = 1'b1;
    #1;
    chk("arst mem_wr",   32'(f_wr),    32'h0);
    chk("arst mem_a",    f_a,          32'h0);
    chk("arst mem_dout", 32'(f_dout),  32'h0);
    chk("arst busy",     32'(bf.busy), 32'h0);
    bf.req = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run(vt[i]);
      n = (vt[i].sz == 2'd0) ? 1 : (vt[i].sz == 2'd1) ? 2 : 4;
      chk($sformatf("v%0d ack_cycle", i), 32'(ack_cyc), 32'(vt[i].exp_ack));
      chk($sformatf("v%0d ack_count", i), 32'(nack), (vt[i].exp_ack > 0) ? 32'h1 : 32'h0);
      if (vt[i].exp_ack > 0)
        chk($sformatf("v%0d ack_bits", i), 32'(ackbits), 32'h1 << vt[i].ch);
      if (vt[i].jp_cyc > 0 && vt[i].exp_ack == 0)
        chk($sformatf("v%0d flush_idle", i), 32'(blog[vt[i].jp_cyc + 1]), 32'h0);
      if (!vt[i].we) begin
        chk($sformatf("v%0d read_no_wr", i), 32'(nwr), 32'h0);
        chk($sformatf("v%0d first_addr", i), alog[vt[i].exp_a1], vt[i].addr);
        if (vt[i].exp_ack > 0) begin
          chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
          if (vt[i].rdy_n == 0) begin
            for (int j = 1; j < n; j++)
              chk($sformatf("v%0d addr%0d", i, j), alog[vt[i].exp_a1 + j], vt[i].addr + 32'(j));
          end else begin
            chk($sformatf("v%0d reissue", i), alog[vt[i].rdy_s + vt[i].rdy_n], vt[i].addr);
          end
        end
      end else begin
        wd = vt[i].wdata;
        chk($sformatf("v%0d wr_count", i), 32'(nwr), 32'(n));
        chk($sformatf("v%0d wr_first", i), 32'(wr1), 32'(vt[i].exp_a1));
        for (int j = 0; j < n && j < nwr; j++) begin
          chk($sformatf("v%0d wr_a%0d", i, j), wlog_a[j], vt[i].addr + 32'(j));
          chk($sformatf("v%0d wr_d%0d", i, j), 32'(wlog_d[j]), 32'(wd[8*j +: 8]));
        end
      end
    end

    // Fixed priority: simultaneous requests, ch0 served first.
    @(negedge clk);
    bf.we = 2'b00; bf.size = 4'b0000;
    bf.addr = {32'h0000_0101, 32'h0000_0100};
    bf.req = 2'b11;
    got = 0;
    for (int j = 0; j < 4; j++) begin ord[j] = '0; rds[j] = '0; end
    for (int c = 1; c < 40 && got < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bf.ack != 2'b00) begin
        ord[got] = bf.ack;
        rds[got] = bf.rdata;
        got++;
        bf.req = bf.req & ~bf.ack;
      end
    end
    bf.req = '0;
    chk("fix grant count", 32'(got),    32'h2);
    chk("fix first",       32'(ord[0]), 32'h1);
    chk("fix second",      32'(ord[1]), 32'h2);
    chk("fix rdata0",      rds[0],      32'h11);
    chk("fix rdata1",      rds[1],      32'h22);

    // Round-robin: both held, grants alternate starting at ch0.
    @(negedge clk);
    br.we = 2'b00; br.size = 4'b0000;
    br.addr = {32'h0000_0101, 32'h0000_0100};
    br.req = 2'b11;
    got = 0;
    for (int j = 0; j < 4; j++) begin ord[j] = '0; rds[j] = '0; end
    for (int c = 1; c < 60 && got < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (br.ack != 2'b00) begin
        ord[got] = br.ack;
        rds[got] = br.rdata;
        got++;
      end
    end
    br.req = '0;
    chk("rr grant count", 32'(got), 32'h4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr grant%0d", j), 32'(ord[j]), (j % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr rdata%0d", j), rds[j],      (j % 2 == 0) ? 32'h11 : 32'h22);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
